// File: rtl/sqrt2_core.sv
// Iterative binary16 square root on a shared tri-state data bus.
// Optional build macro SQRT2_STEP_TRACE_EN shows the partial root on the bus while iterating.
module sqrt2_core #(
    parameter int unsigned DRIVE_START = 2
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic ENABLE,
    inout  wire  [15:0] IO_DATA,
    output logic IS_NAN,
    output logic IS_PINF,
    output logic IS_NINF,
    output logic RESULT
);

    localparam int unsigned DW   = 16;
    localparam int unsigned CW   = 4;
    localparam int unsigned MW   = 10;
    localparam int unsigned XW   = 5;
    localparam int unsigned RW   = 12;
    localparam int unsigned RADW = 24;
    localparam int unsigned REMW = 16;
    localparam int unsigned EW   = 7;

    localparam logic [DW-1:0] QNAN = 16'h7E00;
    localparam logic [DW-1:0] PINF = 16'h7C00;
    localparam logic [CW-1:0] CNT_ROUND = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLASS,
        ST_ROOT,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   op_q, op_d;
    logic [RADW-1:0] rad_q, rad_d;
    logic [REMW-1:0] rem_q, rem_d;
    logic [RW-1:0]   root_q, root_d;
    logic [XW-1:0]   rexp_q, rexp_d;
    logic [DW-1:0]   final_q, final_d;
    logic            nan_q, nan_d;
    logic            pinf_q, pinf_d;
    logic            ninf_q, ninf_d;
    logic            res_q, res_d;

    logic            op_s;
    logic [XW-1:0]   op_e;
    logic [MW-1:0]   op_m;

    assign op_s = op_q[DW-1];
    assign op_e = op_q[DW-2:MW];
    assign op_m = op_q[MW-1:0];

    // Leading-one position of a subnormal mantissa
    logic [CW-1:0] msb_pos;
    logic [CW-1:0] sh;
    always_comb begin
        msb_pos = '0;
        for (int i = 0; i < int'(MW); i++) begin
            if (op_m[i]) msb_pos = CW'(i);
        end
    end
    assign sh = 4'd10 - msb_pos;

    // Unbiased exponent and significand, forced to an even exponent
    logic signed [EW-1:0] exp_unb;
    logic signed [EW-1:0] exp_even;
    logic signed [EW-1:0] exp_half;
    logic [MW:0]          sig;
    logic [MW+1:0]        sigx;
    logic [XW-1:0]        rexp_c;
    logic                 odd;

    always_comb begin
        if (op_e == '0) begin
            sig     = 11'({1'b0, op_m} << sh);
            exp_unb = -7'sd14 - $signed({3'b000, sh});
        end else begin
            sig     = {1'b1, op_m};
            exp_unb = $signed({2'b00, op_e}) - 7'sd15;
        end
        odd      = exp_unb[0];
        sigx     = odd ? {sig, 1'b0} : {1'b0, sig};
        exp_even = exp_unb - $signed({6'b000000, odd});
        exp_half = exp_even >>> 1;
        rexp_c   = XW'(exp_half + 7'sd15);
    end

    // One restoring root step per cycle
    logic [REMW-1:0] rem_sh;
    logic [REMW-1:0] trial;
    logic            take;
    logic [RW-1:0]   root_n;
    logic [REMW-1:0] rem_n;

    assign rem_sh = {rem_q[REMW-3:0], rad_q[RADW-1 -: 2]};
    assign trial  = {2'b00, root_q, 2'b01};
    assign take   = (rem_sh >= trial);
    assign root_n = {root_q[RW-2:0], take};
    assign rem_n  = take ? (rem_sh - trial) : rem_sh;

    // Round to nearest even; the hidden bit carries into the exponent field
    logic            rnd;
    logic [RW-1:0]   mant_r;
    logic [DW-1:0]   packed_c;

    assign rnd      = root_q[0] & ((|rem_q) | root_q[1]);
    assign mant_r   = {1'b0, root_q[RW-1:1]} + RW'(rnd);
    assign packed_c = {1'b0, rexp_q - 5'd1, 10'b0} + DW'(mant_r);

`ifdef SQRT2_STEP_TRACE_EN
    logic [RW-1:0] aligned_c;
    logic [DW-1:0] trace_c;
    assign aligned_c = root_n << (4'd13 - cnt_q);
    assign trace_c   = {1'b0, rexp_q, 10'b0} | (DW'(aligned_c >> 1) & 16'h03FF);
`endif

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rad_d   = rad_q;
        rem_d   = rem_q;
        root_d  = root_q;
        rexp_d  = rexp_q;
        final_d = final_q;
        nan_d   = nan_q;
        pinf_d  = pinf_q;
        ninf_d  = ninf_q;
        res_d   = res_q;

        if (!ENABLE) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            op_d    = '0;
            rad_d   = '0;
            rem_d   = '0;
            root_d  = '0;
            rexp_d  = '0;
            final_d = '0;
            nan_d   = 1'b0;
            pinf_d  = 1'b0;
            ninf_d  = 1'b0;
            res_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    op_d    = IO_DATA;
                    cnt_d   = 4'd1;
                    state_d = ST_CLASS;
                end
                ST_CLASS: begin
                    cnt_d = 4'd2;
                    if (op_e == 5'h1F && op_m != '0) begin
                        final_d = QNAN;
                        nan_d   = 1'b1;
                        res_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (op_e == 5'h1F && !op_s) begin
                        final_d = PINF;
                        pinf_d  = 1'b1;
                        res_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (op_e == 5'h1F) begin
                        final_d = '0;
                        ninf_d  = 1'b1;
                        res_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (op_e == '0 && op_m == '0) begin
                        final_d = op_q;
                        res_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (op_s) begin
                        final_d = QNAN;
                        nan_d   = 1'b1;
                        res_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        rad_d   = {sigx, 12'b0};
                        rem_d   = '0;
                        root_d  = '0;
                        rexp_d  = rexp_c;
                        state_d = ST_ROOT;
`ifdef SQRT2_STEP_TRACE_EN
                        final_d = {1'b0, rexp_c, 10'b0};
`endif
                    end
                end
                ST_ROOT: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == CNT_ROUND) begin
                        final_d = packed_c;
                        res_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        rad_d  = rad_q << 2;
                        rem_d  = rem_n;
                        root_d = root_n;
`ifdef SQRT2_STEP_TRACE_EN
                        final_d = trace_c;
`endif
                    end
                end
                default: begin
                    state_d = ST_DONE;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            rad_q   <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            rexp_q  <= '0;
            final_q <= '0;
            nan_q   <= 1'b0;
            pinf_q  <= 1'b0;
            ninf_q  <= 1'b0;
            res_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rad_q   <= rad_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            rexp_q  <= rexp_d;
            final_q <= final_d;
            nan_q   <= nan_d;
            pinf_q  <= pinf_d;
            ninf_q  <= ninf_d;
            res_q   <= res_d;
        end
    end

    assign IS_NAN  = nan_q;
    assign IS_PINF = pinf_q;
    assign IS_NINF = ninf_q;
    assign RESULT  = res_q;

    // Bus is released whenever ENABLE drops, without waiting for a clock edge
    logic loaded_c;
    logic show_c;
    logic drive_en_c;

    assign loaded_c = (state_q != ST_IDLE);
`ifdef SQRT2_STEP_TRACE_EN
    assign show_c = 1'b1;
`else
    assign show_c = res_q;
`endif
    assign drive_en_c = loaded_c && ENABLE && (cnt_q >= CW'(DRIVE_START)) && show_c;
    assign IO_DATA    = drive_en_c ? final_q : {DW{1'bz}};

endmodule

// File: tb/tb_sqrt2_core.sv
// Randomized self-checking bench for sqrt2_core against a real-arithmetic reference.
// The bus carries a pull-up, so an undriven IO_DATA reads 16'hFFFF.
module tb_sqrt2_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        host_oe;
    logic [15:0] host_data;
    wire  [15:0] io_data;
    logic        is_nan;
    logic        is_pinf;
    logic        is_ninf;
    logic        result;

    int n_err = 0;
    int n_chk = 0;

    localparam logic [15:0] FLOAT_BUS = 16'hFFFF;

    always #5 clk = ~clk;

    assign io_data = host_oe ? host_data : 16'hzzzz;
    pullup pu_io (io_data);

    sqrt2_core #(.DRIVE_START(2)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .ENABLE  (enable),
        .IO_DATA (io_data),
        .IS_NAN  (is_nan),
        .IS_PINF (is_pinf),
        .IS_NINF (is_ninf),
        .RESULT  (result)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic real pow2(input int k);
        real p = 1.0;
        if (k >= 0) repeat (k) p = p * 2.0;
        else repeat (-k) p = p / 2.0;
        return p;
    endfunction

    function automatic real half_to_real(input logic [15:0] h);
        int e = int'(h[14:10]);
        int m = int'(h[9:0]);
        if (e == 0) return real'(m) * pow2(-24);
        return real'(1024 + m) * pow2(e - 25);
    endfunction

    // Round a positive real to binary16, nearest-even
    function automatic logic [15:0] real_to_half(input real x);
        real y = x;
        int  ex = 0;
        int  mi;
        real fr;
        logic [4:0] ef;
        logic [9:0] mf;
        while (y >= 2.0) begin y = y / 2.0; ex++; end
        while (y < 1.0)  begin y = y * 2.0; ex--; end
        y  = y * 1024.0;
        mi = $rtoi(y);
        fr = y - $itor(mi);
        if (fr > 0.5 || (fr == 0.5 && (mi % 2) == 1)) mi++;
        if (mi == 2048) begin mi = 1024; ex++; end
        ef = 5'(ex + 15);
        mf = 10'(mi - 1024);
        return {1'b0, ef, mf};
    endfunction

    // Expected bus value, flags {nan,pinf,ninf} and edges-to-RESULT
    task automatic model(input logic [15:0] a, output logic [15:0] r,
                         output logic [2:0] fl, output int lat);
        lat = 2;
        fl  = 3'b000;
        if (a[14:10] == 5'h1F && a[9:0] != 0) begin r = 16'h7E00; fl = 3'b100; end
        else if (a == 16'h7C00) begin r = 16'h7C00; fl = 3'b010; end
        else if (a == 16'hFC00) begin r = 16'h0000; fl = 3'b001; end
        else if (a[14:0] == 0) begin r = a; end
        else if (a[15]) begin r = 16'h7E00; fl = 3'b100; end
        else begin
            r   = real_to_half($sqrt(half_to_real(a)));
            lat = 15;
        end
    endtask

    task automatic run_op(input logic [15:0] a);
        logic [15:0] er;
        logic [2:0]  ef;
        int          lat;
        model(a, er, ef, lat);
        enable  = 1'b0;
        host_oe = 1'b0;
        step();
        chk($sformatf("idle_out_%h", a), {28'b0, result, is_nan, is_pinf, is_ninf}, 32'd0);
        chk($sformatf("idle_bus_%h", a), 32'(io_data), 32'(FLOAT_BUS));
        host_data = a;
        host_oe   = 1'b1;
        enable    = 1'b1;
        step();
        host_oe = 1'b0;
        #1;
        chk($sformatf("cnt1_bus_%h", a), 32'(io_data), 32'(FLOAT_BUS));
        chk($sformatf("cnt1_res_%h", a), 32'(result), 32'd0);
        for (int k = 2; k <= lat + 1; k++) begin
            step();
            if (k < lat) begin
                chk($sformatf("early_res_%h_k%0d", a, k), 32'(result), 32'd0);
`ifndef SQRT2_STEP_TRACE_EN
                chk($sformatf("early_bus_%h_k%0d", a, k), 32'(io_data), 32'(FLOAT_BUS));
`endif
            end else begin
                chk($sformatf("res_valid_%h_k%0d", a, k), 32'(result), 32'd1);
                chk($sformatf("res_data_%h_k%0d", a, k), 32'(io_data), 32'(er));
                chk($sformatf("res_flags_%h_k%0d", a, k), 32'({is_nan, is_pinf, is_ninf}), 32'(ef));
            end
        end
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_out"}, {28'b0, result, is_nan, is_pinf, is_ninf}, 32'd0);
        chk({tag, "_bus"}, 32'(io_data), 32'(FLOAT_BUS));
    endtask

    logic [15:0] directed [15] = '{16'h3C00, 16'h4000, 16'h4400, 16'h0001, 16'h0000,
                                   16'h8000, 16'h7C00, 16'hFC00, 16'h7E00, 16'hC000,
                                   16'h7BFF, 16'h03FF, 16'h8001, 16'hFC01, 16'h0400};

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        host_oe   = 1'b0;
        host_data = '0;
        step();
        step();
        check_cleared("reset");
        rst_n = 1'b1;

        foreach (directed[i]) run_op(directed[i]);

        // Abort at counter 6, then a clean restart
        enable = 1'b0;
        step();
        host_data = 16'h4000;
        host_oe   = 1'b1;
        enable    = 1'b1;
        step();
        host_oe = 1'b0;
        repeat (5) step();
        enable = 1'b0;
        #1;
        chk("abort_bus_now", 32'(io_data), 32'(FLOAT_BUS));
        step();
        check_cleared("abort");
        run_op(16'h3C00);

        // Reset while a special result is held, with ENABLE still high
        run_op(16'h7C00);
        rst_n = 1'b0;
        step();
        check_cleared("rst_held");
        rst_n = 1'b1;

        // Reset mid-iteration
        enable = 1'b0;
        step();
        host_data = 16'h4400;
        host_oe   = 1'b1;
        enable    = 1'b1;
        step();
        host_oe = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        check_cleared("rst_mid");
        rst_n  = 1'b1;
        enable = 1'b0;
        run_op(16'h4400);

        for (int n = 0; n < 150; n++) begin
            logic [15:0] a;
            a = 16'($urandom);
            if (n % 3 != 0) a[15] = 1'b0;
            run_op(a);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
